// File: rtl/pong_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_scoreboard_if
// Brief    : Point-event inputs and score/display outputs of the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface pong_scoreboard_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic                            point_valid;
  logic [PW-1:0]                   point_player;
  logic                            new_game;
  logic [4*DIGITS*NUM_PLAYERS-1:0] scores;
  logic                            serve_ready;
  logic                            game_over;
  logic [PW-1:0]                   winner;
  logic [7*DIGITS*NUM_PLAYERS-1:0] seg;

  modport master (
    output point_valid, point_player, new_game,
    input  scores, serve_ready, game_over, winner, seg
  );

  modport slave (
    input  point_valid, point_player, new_game,
    output scores, serve_ready, game_over, winner, seg
  );
endinterface
`default_nettype wire

// File: rtl/pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pong_scoreboard
// Brief    : Multi-player BCD score unit with serve-hold/game-over FSM and
//            7-segment decode. Define SCORE_WIN_BY_TWO_EN for win-by-two.
// Revision : 1.0 - initial release
// ============================================================================
module pong_scoreboard #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DIGITS         = 2,
  parameter int WIN_SCORE      = 11,
  parameter int HOLD_CYCLES    = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  pong_scoreboard_if.slave     sb_if
);
  localparam int PW        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int c_score_w = 4 * DIGITS;
  localparam int c_all_w   = c_score_w * NUM_PLAYERS;
  localparam int c_cnt_w   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HOLD = 2'd1,
    S_OVER = 2'd2
  } state_t;

  function automatic logic [c_score_w-1:0] all_nines();
    logic [c_score_w-1:0] v;
    for (int d = 0; d < DIGITS; d++) v[4*d +: 4] = 4'd9;
    return v;
  endfunction

  // Ripple BCD increment; an all-9s score saturates instead of wrapping.
  function automatic logic [c_score_w-1:0] bcd_inc(input logic [c_score_w-1:0] v);
    logic [c_score_w-1:0] r;
    logic                 carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return (v == all_nines()) ? v : r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

`ifdef SCORE_WIN_BY_TWO_EN
  function automatic int bcd_to_bin(input logic [c_score_w-1:0] v);
    int acc;
    acc = 0;
    for (int d = DIGITS - 1; d >= 0; d--) acc = acc * 10 + int'(v[4*d +: 4]);
    return acc;
  endfunction
`else
  function automatic logic [c_score_w-1:0] to_bcd(input int n);
    logic [c_score_w-1:0] v;
    int                   t;
    v = '0;
    t = n;
    for (int d = 0; d < DIGITS; d++) begin
      v[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  localparam logic [c_score_w-1:0] c_win_bcd = to_bcd(WIN_SCORE);
`endif

  state_t               r_state, w_state_nxt;
  logic [c_all_w-1:0]   r_scores, w_scores_nxt;
  logic [PW-1:0]        r_winner, w_winner_nxt;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
  logic [c_score_w-1:0] w_sel_score, w_inc_score;
  logic                 w_player_ok, w_win;
`ifdef SCORE_WIN_BY_TWO_EN
  int                   w_new_bin;
`endif

  always_comb begin
    w_sel_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (sb_if.point_player == PW'(p)) w_sel_score = r_scores[p*c_score_w +: c_score_w];
    end
    w_inc_score = bcd_inc(w_sel_score);
    w_player_ok = ({{(32-PW){1'b0}}, sb_if.point_player} < 32'(NUM_PLAYERS));
`ifdef SCORE_WIN_BY_TWO_EN
    // BCD is converted to binary so the lead-of-two test is plain arithmetic.
    w_new_bin = bcd_to_bin(w_inc_score);
    w_win     = (w_new_bin >= WIN_SCORE);
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if ((sb_if.point_player != PW'(q)) &&
          (bcd_to_bin(r_scores[q*c_score_w +: c_score_w]) + 2 > w_new_bin)) w_win = 1'b0;
    end
`else
    w_win = (w_inc_score >= c_win_bcd);
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_scores_nxt = r_scores;
    w_winner_nxt = r_winner;
    w_cnt_nxt    = r_cnt;
    if (sb_if.new_game) begin
      w_state_nxt  = S_HOLD;
      w_scores_nxt = '0;
      w_winner_nxt = '0;
      w_cnt_nxt    = c_hold_load;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (sb_if.point_valid && w_player_ok) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (sb_if.point_player == PW'(p)) w_scores_nxt[p*c_score_w +: c_score_w] = w_inc_score;
            end
            if (w_win) begin
              w_state_nxt  = S_OVER;
              w_winner_nxt = sb_if.point_player;
            end else begin
              w_state_nxt = S_HOLD;
              w_cnt_nxt   = c_hold_load;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) w_state_nxt = S_PLAY;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        S_OVER:  ;
        default: w_state_nxt = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_PLAY;
      r_scores <= '0;
      r_winner <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_scores <= w_scores_nxt;
      r_winner <= w_winner_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign sb_if.scores      = r_scores;
  assign sb_if.serve_ready = (r_state == S_PLAY);
  assign sb_if.game_over   = (r_state == S_OVER);
  assign sb_if.winner      = r_winner;

  for (genvar i = 0; i < DIGITS * NUM_PLAYERS; i++) begin : g_seg
    assign sb_if.seg[7*i +: 7] = seg_decode(r_scores[4*i +: 4]) ^ {7{SEG_ACTIVE_LOW != 0}};
  end
endmodule
`default_nettype wire

// File: tb/tb_pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_scoreboard
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_scoreboard;
  localparam int NP   = 3;
  localparam int D    = 2;
  localparam int WIN  = 11;
  localparam int HOLD = 4;
  localparam int SAL  = 1;
  localparam int PW   = 2;
  localparam int SW   = 4 * D * NP;
  localparam int GW   = 7 * D * NP;
  localparam int MAXS = 99;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pong_scoreboard_if #(.NUM_PLAYERS(NP), .DIGITS(D)) sb_if ();

  pong_scoreboard #(
    .NUM_PLAYERS(NP), .DIGITS(D), .WIN_SCORE(WIN),
    .HOLD_CYCLES(HOLD), .SEG_ACTIVE_LOW(SAL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sb_if (sb_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: scores as plain integers, hold as cycles remaining.
  int m_score [NP];
  int m_hold;
  bit m_over;
  int m_winner;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_score[p] = 0;
    m_hold = 0; m_over = 0; m_winner = 0;
  endtask

  function automatic bit model_wins(input int pp);
`ifdef SCORE_WIN_BY_TWO_EN
    bit ok;
    ok = (m_score[pp] >= WIN);
    for (int q = 0; q < NP; q++)
      if (q != pp && m_score[pp] < m_score[q] + 2) ok = 0;
    return ok;
`else
    return m_score[pp] >= WIN;
`endif
  endfunction

  task automatic model_step(input bit pv, input int pp, input bit ng);
    if (ng) begin
      for (int p = 0; p < NP; p++) m_score[p] = 0;
      m_winner = 0; m_over = 0; m_hold = HOLD;
    end else if (m_over) begin
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (pv && pp < NP) begin
      if (m_score[pp] < MAXS) m_score[pp]++;
      if (model_wins(pp)) begin m_over = 1; m_winner = pp; end
      else m_hold = HOLD;
    end
  endtask

  function automatic logic [SW-1:0] exp_scores();
    logic [SW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < D; d++)
        v[4*(p*D+d) +: 4] = 4'((m_score[p] / (10**d)) % 10);
    return v;
  endfunction

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [GW-1:0] exp_seg();
    logic [GW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < D; d++)
        v[7*(p*D+d) +: 7] = (SAL != 0) ? ~glyph((m_score[p] / (10**d)) % 10)
                                       :  glyph((m_score[p] / (10**d)) % 10);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".scores"}, 64'(sb_if.scores), 64'(exp_scores()));
    chk({tag, ".seg"}, 64'(sb_if.seg), 64'(exp_seg()));
    chk({tag, ".serve_ready"}, 64'(sb_if.serve_ready), 64'(!m_over && m_hold == 0));
    chk({tag, ".game_over"}, 64'(sb_if.game_over), 64'(m_over));
    chk({tag, ".winner"}, 64'(sb_if.winner), 64'(m_winner));
  endtask

  task automatic apply(input bit pv, input int pp, input bit ng, input string tag);
    sb_if.point_valid  = pv;
    sb_if.point_player = PW'(pp);
    sb_if.new_game     = ng;
    @(posedge clock);
    model_step(pv, pp, ng);
    #1;
    check_all(tag);
  endtask

  task automatic score_point(input int p);
    apply(1, p, 0, "pt");
    repeat (HOLD) apply(0, 0, 0, "hold");
  endtask

  typedef struct {
    bit            pv;
    int            pp;
    bit            ng;
    logic [SW-1:0] e_scores;
    bit            e_ready;
    bit            e_over;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 1, 0, 24'h000100, 0, 0};
    tbl[1]  = '{1, 1, 0, 24'h000100, 0, 0};
    tbl[2]  = '{0, 0, 0, 24'h000100, 0, 0};
    tbl[3]  = '{0, 0, 0, 24'h000100, 0, 0};
    tbl[4]  = '{0, 0, 0, 24'h000100, 1, 0};
    tbl[5]  = '{1, 3, 0, 24'h000100, 1, 0};
    tbl[6]  = '{1, 1, 1, 24'h000000, 0, 0};
    tbl[7]  = '{0, 0, 0, 24'h000000, 0, 0};
    tbl[8]  = '{0, 0, 0, 24'h000000, 0, 0};
    tbl[9]  = '{0, 0, 0, 24'h000000, 0, 0};
    tbl[10] = '{0, 0, 0, 24'h000000, 1, 0};

    sb_if.point_valid  = 0;
    sb_if.point_player = '0;
    sb_if.new_game     = 0;
    model_reset();
    #2;
    check_all("reset");
    chk("reset.seg_zero", 64'(sb_if.seg), 64'({6{7'b1000000}}));
    @(negedge clock);
    reset = 0;
    apply(0, 0, 0, "post_reset");

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].pv, tbl[i].pp, tbl[i].ng, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_scores", i), 64'(sb_if.scores), 64'(tbl[i].e_scores));
      chk($sformatf("vec%0d.tbl_ready", i), 64'(sb_if.serve_ready), 64'(tbl[i].e_ready));
      chk($sformatf("vec%0d.tbl_over", i), 64'(sb_if.game_over), 64'(tbl[i].e_over));
    end

    repeat (10) score_point(0);
    chk("carry.score", 64'(sb_if.scores[7:0]), 64'(8'h10));
    chk("carry.seg_hi", 64'(sb_if.seg[13:7]), 64'(7'b1111001));
    chk("carry.seg_lo", 64'(sb_if.seg[6:0]), 64'(7'b1000000));
    repeat (10) score_point(1);

`ifdef SCORE_WIN_BY_TWO_EN
    score_point(1);
    chk("by2.no_win", 64'(sb_if.game_over), 64'(0));
    chk("by2.p1_11", 64'(sb_if.scores[15:8]), 64'(8'h11));
    apply(1, 1, 0, "by2.win");
    chk("by2.over", 64'(sb_if.game_over), 64'(1));
    chk("by2.winner", 64'(sb_if.winner), 64'(1));
    chk("by2.p1_12", 64'(sb_if.scores[15:8]), 64'(8'h12));
`else
    apply(1, 0, 0, "win");
    chk("win.over", 64'(sb_if.game_over), 64'(1));
    chk("win.winner", 64'(sb_if.winner), 64'(0));
    chk("win.p0_11", 64'(sb_if.scores[7:0]), 64'(8'h11));
    apply(1, 0, 0, "frozen");
    chk("win.frozen", 64'(sb_if.scores[7:0]), 64'(8'h11));
`endif
    apply(0, 0, 1, "newgame");
    chk("newgame.scores", 64'(sb_if.scores), 64'(0));
    chk("newgame.ready", 64'(sb_if.serve_ready), 64'(0));
    chk("newgame.over", 64'(sb_if.game_over), 64'(0));
    repeat (HOLD) apply(0, 0, 0, "newgame.hold");

    // Asynchronous reset in the middle of a serve hold.
    apply(1, 2, 0, "ar.pt");
    apply(0, 0, 0, "ar.hold");
    reset = 1;
    #1;
    model_reset();
    chk("areset.ready", 64'(sb_if.serve_ready), 64'(1));
    chk("areset.scores", 64'(sb_if.scores), 64'(0));
    #2;
    reset = 0;
    apply(1, 2, 0, "ar.first_edge");
    chk("areset.first_point", 64'(sb_if.scores[23:16]), 64'(8'h01));
    repeat (HOLD) apply(0, 0, 0, "ar.hold2");

    for (int i = 0; i < 3000; i++)
      apply(($urandom % 3) == 0, int'($urandom % 4), ($urandom % 150) == 0, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
